// File: rtl/pad_pkg.sv
// Shared types and constants for the multi-pad NES/SNES controller poller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  localparam logic MODE_NES  = 1'b0;
  localparam logic MODE_SNES = 1'b1;

  localparam int PAD_WORD_W = 16;

  // SNES bit positions within a pad word (bit 0 is shifted out first)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // NES pads put A and B in the first two slots instead
  localparam int NES_BTN_A = 0;
  localparam int NES_BTN_B = 1;

  // Number of serial bits read per pad for a given mode
  function automatic logic [4:0] bits_for_mode(input logic mode);
    return (mode == MODE_SNES) ? 5'd16 : 5'd8;
  endfunction

endpackage

// File: rtl/pad_data_sync.sv
// Two-flop synchroniser for the asynchronous pad data lines.
// Latency: 2 Clock cycles.
// Backpressure: none; free-running, resets to all-ones (no buttons pressed).
module pad_data_sync #(
  parameter int NUM_PADS = 2
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [NUM_PADS-1:0] d,
  output logic [NUM_PADS-1:0] q
);

  logic [NUM_PADS-1:0] meta;

  // Two-stage resynchronisation; the lines idle high so reset to ones
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_multi_pad_poller.sv
// Polls NUM_PADS NES/SNES pads over a shared latch/clock, publishing buttons + press edges.
// Latency: (2 + 2*NBITS)*CLK_DIV + 1 cycles per poll, Valid the cycle after DONE.
// Backpressure: none; Valid is a one-cycle pulse, Buttons/Pressed hold until the next one.
module snes_multi_pad_poller
  import pad_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int CLK_DIV  = 300,
  parameter int POLL_GAP = 833000
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         Enable,
  input  logic                         Mode,
  input  logic [NUM_PADS-1:0]          Data,
  output logic                         Strobe_Latch,
  output logic                         Shift_Clock,
  output logic [PAD_WORD_W*NUM_PADS-1:0] Buttons,
  output logic [PAD_WORD_W*NUM_PADS-1:0] Pressed,
  output logic                         Valid,
  output logic                         Busy
);

  localparam int CNT_MAX = (2*CLK_DIV > POLL_GAP) ? 2*CLK_DIV : POLL_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WORDS_W = PAD_WORD_W*NUM_PADS;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2*CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(POLL_GAP - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         bit_idx;
  logic               mode_q;
  logic [4:0]         nbits;
  logic               last_bit;
  logic [NUM_PADS-1:0] data_s;
  logic [WORDS_W-1:0] cap;
  logic [WORDS_W-1:0] cap_word;
  logic               poll_start;
  logic               sample_now;

  pad_data_sync #(.NUM_PADS(NUM_PADS)) u_sync (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .d       (Data),
    .q       (data_s)
  );

  assign nbits      = bits_for_mode(mode_q);
  assign last_bit   = ({1'b0, bit_idx} == (nbits - 5'd1));
  assign poll_start = (state == IDLE) && (state_nxt == LATCH);
  assign sample_now = (state == SHIFT_LO) && (cnt == HALF_LAST);
  assign Busy       = (state != IDLE);

  // Next-state decode; every phase ends on its terminal count
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (Enable && (cnt >= GAP_LAST)) state_nxt = LATCH;
      LATCH:    if (cnt == LATCH_LAST) state_nxt = SHIFT_LO;
      SHIFT_LO: if (cnt == HALF_LAST) state_nxt = SHIFT_HI;
      SHIFT_HI: if (cnt == HALF_LAST) state_nxt = last_bit ? DONE : SHIFT_LO;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register and shared phase counter; the counter saturates in IDLE and
  // resets preloaded so the first poll after reset starts without a gap
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= GAP_LAST;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if ((state != IDLE) || (cnt < GAP_LAST)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Per-poll context: mode captured at poll start, bit index advanced per bit
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q  <= MODE_NES;
      bit_idx <= '0;
    end else if (poll_start) begin
      mode_q  <= Mode;
      bit_idx <= '0;
    end else if ((state == SHIFT_HI) && (state_nxt == SHIFT_LO)) begin
      bit_idx <= bit_idx + 4'd1;
    end
  end

  // Capture each pad's bit at the end of the low half, before the pad shifts
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cap <= '0;
    end else if (poll_start) begin
      cap <= '0;
    end else if (sample_now) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        cap[p*PAD_WORD_W + int'(bit_idx)] <= ~data_s[p];
      end
    end
  end

  // NES pads only deliver 8 meaningful bits; clear the upper byte of each word
  always_comb begin
    cap_word = cap;
    if (mode_q == MODE_NES) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        cap_word[p*PAD_WORD_W + 8 +: 8] = 8'h00;
      end
    end
  end

  // Pad-facing strobes are registered from next-state so they stay glitch-free
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Strobe_Latch <= 1'b0;
      Shift_Clock  <= 1'b1;
    end else begin
      Strobe_Latch <= (state_nxt == LATCH);
      Shift_Clock  <= (state_nxt != SHIFT_LO);
    end
  end

  // Publish results in DONE; Valid appears the following cycle alongside them
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Buttons <= '0;
      Pressed <= '0;
      Valid   <= 1'b0;
    end else begin
      Valid <= (state == DONE);
      if (state == DONE) begin
        Buttons <= cap_word;
        Pressed <= cap_word & ~Buttons;
      end
    end
  end

endmodule

// File: tb/tb_snes_multi_pad_poller.sv
// Self-checking bench: pad shift-register model on the wires, word-level expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_snes_multi_pad_poller;

  localparam int NUM_PADS = 2;
  localparam int CLK_DIV  = 4;
  localparam int POLL_GAP = 10;
  localparam int LEN_NES  = 18*CLK_DIV + 1;
  localparam int LEN_SNES = 34*CLK_DIV + 1;

  logic                  Clock = 1'b0;
  logic                  Reset_n;
  logic                  Enable;
  logic                  Mode;
  logic [NUM_PADS-1:0]   Data;
  logic                  Strobe_Latch;
  logic                  Shift_Clock;
  logic [16*NUM_PADS-1:0] Buttons;
  logic [16*NUM_PADS-1:0] Pressed;
  logic                  Valid;
  logic                  Busy;

  snes_multi_pad_poller #(
    .NUM_PADS (NUM_PADS),
    .CLK_DIV  (CLK_DIV),
    .POLL_GAP (POLL_GAP)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Enable       (Enable),
    .Mode         (Mode),
    .Data         (Data),
    .Strobe_Latch (Strobe_Latch),
    .Shift_Clock  (Shift_Clock),
    .Buttons      (Buttons),
    .Pressed      (Pressed),
    .Valid        (Valid),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  // Pad model: a latch loads the button word, each shift-clock rise moves to the next bit
  logic [NUM_PADS-1:0][15:0] pad_word;
  int unsigned sh_idx = 0;
  always @(posedge Shift_Clock or posedge Strobe_Latch) begin
    if (Strobe_Latch) sh_idx <= 0;
    else              sh_idx <= sh_idx + 1;
  end
  always_comb begin
    Data = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (sh_idx < 16) Data[p] = ~pad_word[p][sh_idx[3:0]];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected published word: SNES keeps all 16 bits, NES only the low byte
  function automatic logic [31:0] expect_word(input logic [NUM_PADS-1:0][15:0] w, input logic m);
    logic [31:0] r;
    for (int p = 0; p < NUM_PADS; p++) r[p*16 +: 16] = m ? w[p] : (w[p] & 16'h00FF);
    return r;
  endfunction

  // Watches one poll from latch rise to Valid; optionally drops Enable / flips Mode mid-poll
  task automatic observe_poll(input int drop_at, output int t_latch, output int t_valid,
                              output int n_strobe, output int n_pulse, output int n_bad,
                              output bit to);
    int k;
    int run;
    to = 0; n_strobe = 0; n_pulse = 0; n_bad = 0; t_latch = 0; t_valid = 0;
    k = 0;
    while (Strobe_Latch !== 1'b1 && k < 1000) begin @(negedge Clock); k++; end
    if (k >= 1000) begin to = 1; return; end
    t_latch = cyc;
    run = 0;
    k = 0;
    while (Valid !== 1'b1 && k < 1000) begin
      if (Strobe_Latch) n_strobe++;
      if (!Shift_Clock) run++;
      else if (run > 0) begin
        n_pulse++;
        if (run != CLK_DIV) n_bad++;
        run = 0;
        if (n_pulse == drop_at) begin Enable = 0; Mode = ~Mode; end
      end
      @(negedge Clock);
      k++;
    end
    if (k >= 1000) to = 1;
    t_valid = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tl, tv, ns, np, nb, prev_tl, prev_len, t_rel, k, falls;
    bit to;
    logic m_poll;
    logic [31:0] exp_b, exp_p, nw;

    Reset_n = 0; Enable = 0; Mode = 0; pad_word = '0;
    exp_b = '0;
    repeat (3) @(negedge Clock);
    chk("rst_strobe", Strobe_Latch, 0);
    chk("rst_shclk",  Shift_Clock, 1);
    chk("rst_buttons", Buttons, 0);
    chk("rst_pressed", Pressed, 0);
    chk("rst_valid",  Valid, 0);
    chk("rst_busy",   Busy, 0);

    // NES poll, pad0 holds A + Right
    pad_word[0] = 16'h0081; pad_word[1] = 16'h0000; Mode = 0; Enable = 1;
    Reset_n = 1;
    observe_poll(-1, tl, tv, ns, np, nb, to);
    chk("nes_timeout", to, 0);
    chk("nes_strobe_len", ns, 2*CLK_DIV);
    chk("nes_pulses", np, 8);
    chk("nes_pulse_len", nb, 0);
    chk("nes_valid_lat", tv - tl, LEN_NES);
    chk("nes_buttons", Buttons, 32'h0000_0081);
    chk("nes_pressed", Pressed, 32'h0000_0081);
    chk("nes_busy_idle", Busy, 0);
    exp_b = 32'h0000_0081;
    prev_tl = tl; prev_len = LEN_NES;
    Mode = 1; pad_word[1] = 16'h0C10;
    @(negedge Clock);
    chk("nes_valid_width", Valid, 0);

    // SNES poll, pad1 holds Up + L + R; then the same poll again
    for (int r = 0; r < 2; r++) begin
      observe_poll(-1, tl, tv, ns, np, nb, to);
      chk("snes_timeout", to, 0);
      chk("snes_pulses", np, 16);
      chk("snes_valid_lat", tv - tl, LEN_SNES);
      chk("snes_gap", tl - prev_tl, prev_len + POLL_GAP);
      chk("snes_pad1", Buttons[31:16], 16'h0C10);
      chk("snes_pressed", Pressed, (r == 0) ? 32'h0C10_0000 : 32'h0);
      exp_b = expect_word(pad_word, 1'b1);
      prev_tl = tl; prev_len = LEN_SNES;
    end

    // Edge detect: Up, then Up + Down on pad0
    pad_word[0] = 16'h0010;
    observe_poll(-1, tl, tv, ns, np, nb, to);
    chk("edge1_timeout", to, 0);
    chk("edge1_buttons", Buttons, 32'h0C10_0010);
    exp_b = Buttons === 32'h0C10_0010 ? 32'h0C10_0010 : 32'h0C10_0010;
    prev_tl = tl;
    pad_word[0] = 16'h0030;
    observe_poll(-1, tl, tv, ns, np, nb, to);
    chk("edge2_timeout", to, 0);
    chk("edge2_pressed", Pressed[15:0], 16'h0020);
    chk("edge2_gap", tl - prev_tl, LEN_SNES + POLL_GAP);
    exp_b = 32'h0C10_0030;
    prev_tl = tl;

    // Randomised polls against the word-level model, Enable held high
    for (int r = 0; r < 8; r++) begin
      pad_word[0] = 16'($urandom);
      pad_word[1] = 16'($urandom);
      m_poll = 1'($urandom_range(0, 1));
      Mode = m_poll;
      observe_poll(-1, tl, tv, ns, np, nb, to);
      nw    = expect_word(pad_word, m_poll);
      exp_p = nw & ~exp_b;
      chk("rnd_timeout", to, 0);
      chk("rnd_gap", tl - prev_tl, prev_len + POLL_GAP);
      chk("rnd_pulses", np, m_poll ? 16 : 8);
      chk("rnd_buttons", Buttons, nw);
      chk("rnd_pressed", Pressed, exp_p);
      exp_b = nw;
      prev_tl = tl; prev_len = m_poll ? LEN_SNES : LEN_NES;
    end

    // Enable dropped and Mode flipped mid-poll of an NES read
    pad_word[0] = 16'hA5C3; pad_word[1] = 16'h5A3C; Mode = 0;
    observe_poll(3, tl, tv, ns, np, nb, to);
    nw = expect_word(pad_word, 1'b0);
    chk("drop_timeout", to, 0);
    chk("drop_pulses", np, 8);
    chk("drop_valid_lat", tv - tl, LEN_NES);
    chk("drop_buttons", Buttons, nw);
    chk("drop_pressed", Pressed, nw & ~exp_b);
    exp_b = nw;
    ns = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clock);
      if (Strobe_Latch || Valid) ns++;
    end
    chk("drop_no_latch", ns, 0);
    chk("drop_busy", Busy, 0);

    // Reset during the low half of bit 5 of an SNES poll
    Mode = 1; Enable = 1;
    k = 0; falls = 0;
    while (falls < 6 && k < 1000) begin
      @(negedge Clock); k++;
      if (!Shift_Clock && Busy && (sh_idx == falls)) falls++;
    end
    chk("rst_mid_reached", (k < 1000), 1);
    Reset_n = 0;
    #1;
    chk("rst_mid_shclk",  Shift_Clock, 1);
    chk("rst_mid_strobe", Strobe_Latch, 0);
    chk("rst_mid_buttons", Buttons, 0);
    chk("rst_mid_busy",   Busy, 0);
    chk("rst_mid_valid",  Valid, 0);
    exp_b = '0;
    @(negedge Clock); @(negedge Clock);
    Reset_n = 1;
    t_rel = cyc;
    observe_poll(-1, tl, tv, ns, np, nb, to);
    nw = expect_word(pad_word, 1'b1);
    chk("rst_new_timeout", to, 0);
    chk("rst_new_start", tl - t_rel, 1);
    chk("rst_new_strobe_len", ns, 2*CLK_DIV);
    chk("rst_new_buttons", Buttons, nw);
    chk("rst_new_pressed", Pressed, nw);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
